// File: rtl/debug_controller.sv
// debug_controller: sequences debugger register loads, port sends, core ack wait and core halt/reset requests (optional ack timeout under DEBUG_TIMEOUT_EN)
module debug_controller #(
    parameter int OPC_W          = 4,
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [OPC_W-1:0] debug_opcode,
    input  logic             core_ack,
    input  logic             core_halted,
    output logic             core_reset_request,
    output logic             core_halt_request,
    output logic             load_debug_command,
    output logic             load_debug_command_address_argument,
    output logic             load_debug_command_data_argument,
    output logic             send_debug_command,
    output logic             send_debug_command_address_argument,
    output logic             send_debug_command_data_argument,
    output logic             load_debug_result,
    output logic             busy,
    output logic             done,
    output logic             result_valid,
    output logic             error
);
    localparam int RC_W = $clog2(RESET_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_DATA, CHECK, SEND_CMD, SEND_ADDR, SEND_DATA, WAIT_ACK, RST_PULSE, DONE
    } state_t;

    state_t            state, next;
    logic              is_write;
    logic [RC_W-1:0]   rst_cnt;
    logic              xfer, op_simple, op_access, op_illegal, ack_timeout;
`ifdef DEBUG_TIMEOUT_EN
    logic [15:0]       to_cnt;
    assign ack_timeout = (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign ack_timeout = 1'b0;
`endif

    assign instr_ready = (state == IDLE) || (state == GET_ADDR) || (state == GET_DATA);
    assign xfer        = instr_valid && instr_ready;
    assign op_simple   = (debug_opcode < OPC_W'(3));
    assign op_access   = (debug_opcode >= OPC_W'(4)) && (debug_opcode <= OPC_W'(7));
    assign op_illegal  = (debug_opcode > OPC_W'(7));
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    // next-state decode plus the combinational load strobes of each transfer cycle
    always_comb begin
        next = state;
        load_debug_command = 1'b0;
        load_debug_command_address_argument = 1'b0;
        load_debug_command_data_argument = 1'b0;
        load_debug_result = 1'b0;
        case (state)
            IDLE: if (xfer) begin
                load_debug_command = 1'b1;
                next = op_access ? GET_ADDR : (op_simple || op_illegal) ? DONE : RST_PULSE;
            end
            GET_ADDR: if (xfer) begin
                load_debug_command_address_argument = 1'b1;
                next = is_write ? GET_DATA : CHECK;
            end
            GET_DATA: if (xfer) begin
                load_debug_command_data_argument = 1'b1;
                next = CHECK;
            end
            CHECK:     next = core_halted ? SEND_CMD : DONE;
            SEND_CMD:  next = SEND_ADDR;
            SEND_ADDR: next = is_write ? SEND_DATA : WAIT_ACK;
            SEND_DATA: next = WAIT_ACK;
            WAIT_ACK: begin
                load_debug_result = core_ack && !is_write;
                next = (core_ack || ack_timeout) ? DONE : WAIT_ACK;
            end
            RST_PULSE: next = (rst_cnt == '0) ? DONE : RST_PULSE;
            default:   next = IDLE;
        endcase
    end

    // state, sticky flags, pulse counter and registered port enables
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            is_write <= 1'b0;
            rst_cnt <= '0;
            core_halt_request <= 1'b0;
            core_reset_request <= 1'b0;
            error <= 1'b0;
            result_valid <= 1'b0;
            send_debug_command <= 1'b0;
            send_debug_command_address_argument <= 1'b0;
            send_debug_command_data_argument <= 1'b0;
        end else begin
            state <= next;
            rst_cnt <= (state == IDLE) ? RC_W'(RESET_CYCLES - 1) : rst_cnt - RC_W'(state == RST_PULSE);
            if (state == IDLE && xfer) begin
                is_write <= debug_opcode[0];
                error <= op_illegal;
                core_halt_request <= (debug_opcode == OPC_W'(1)) ? 1'b1 :
                                     (debug_opcode == OPC_W'(2)) ? 1'b0 : core_halt_request;
            end
            if ((state == CHECK && !core_halted) || (state == WAIT_ACK && !core_ack && ack_timeout))
                error <= 1'b1;
            result_valid <= (state == WAIT_ACK) && core_ack && !is_write;
            core_reset_request <= (next == RST_PULSE);
            send_debug_command <= (next == SEND_CMD);
            send_debug_command_address_argument <= (next == SEND_ADDR);
            send_debug_command_data_argument <= (next == SEND_DATA);
        end
    end

`ifdef DEBUG_TIMEOUT_EN
    // ack wait counter, zero outside WAIT_ACK so it restarts on every entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) to_cnt <= '0;
        else      to_cnt <= (state == WAIT_ACK) ? to_cnt + 16'd1 : '0;
    end
`endif
endmodule

// File: tb/tb_debug_controller.sv
// tb_debug_controller: directed plus random command stream checked against a transaction-level expectation model
module tb_debug_controller;
    localparam int RC = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid, instr_ready, core_ack, core_halted;
    logic [3:0] debug_opcode;
    logic       core_reset_request, core_halt_request;
    logic       load_cmd, load_addr, load_data, load_result;
    logic       send_cmd, send_addr, send_data;
    logic       busy, done, result_valid, error;

    int n_assert = 0;
    int n_fail = 0;
    bit halt_m = 0;
    bit err_m = 0;
    bit mon_en = 0;

    always #5 clk = ~clk;

    debug_controller #(.OPC_W(4), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .debug_opcode(debug_opcode), .core_ack(core_ack), .core_halted(core_halted),
        .core_reset_request(core_reset_request), .core_halt_request(core_halt_request),
        .load_debug_command(load_cmd), .load_debug_command_address_argument(load_addr),
        .load_debug_command_data_argument(load_data), .send_debug_command(send_cmd),
        .send_debug_command_address_argument(send_addr), .send_debug_command_data_argument(send_data),
        .load_debug_result(load_result), .busy(busy), .done(done), .result_valid(result_valid), .error(error)
    );

    function automatic logic [13:0] obs();
        return {instr_ready, busy, done, result_valid, error, core_reset_request, core_halt_request,
                send_cmd, send_addr, send_data, load_cmd, load_addr, load_data, load_result};
    endfunction

    function automatic logic [13:0] ev(input bit rdy, bsy, dn, rv, rr, input logic [2:0] snd, input logic [3:0] ld);
        return {rdy, bsy, dn, rv, err_m, rr, halt_m, snd, ld};
    endfunction

    task automatic chk(input string tag, input logic [13:0] e);
        #1;
        n_assert++;
        assert (obs() === e) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs(), e);
        end
    endtask

    task automatic step(input bit ack, input bit iv);
        @(negedge clk);
        core_ack = ack;
        instr_valid = iv;
        debug_opcode = 4'($urandom);
    endtask

    task automatic word(input logic [3:0] val, input int gap, input bit bsy, input logic [3:0] ld);
        repeat (gap) begin
            step(1'($urandom_range(0, 1)), 1'b0);
            chk("word_gap", ev(1, bsy, 0, 0, 0, 3'b000, 4'b0000));
        end
        step(1'($urandom_range(0, 1)), 1'b1);
        debug_opcode = val;
        chk("word_xfer", ev(1, bsy, 0, 0, 0, 3'b000, ld));
    endtask

    task automatic run_cmd(input logic [3:0] opc, input bit halted, input int ackw, input int gap, input bit no_ack);
        bit acc, wr, rd, rv;
        acc = (opc >= 4 && opc <= 7);
        wr = acc && (opc == 5 || opc == 7);
        rd = acc && !wr;
        rv = 0;
        core_halted = halted;
        word(opc, gap, 0, 4'b1000);
        err_m = (opc > 7);
        if (opc == 1) halt_m = 1;
        if (opc == 2) halt_m = 0;
        if (acc) word(4'($urandom), gap, 1, 4'b0100);
        if (wr) word(4'($urandom), gap, 1, 4'b0010);
        if (opc == 3) begin
            repeat (RC) begin
                step(1'($urandom_range(0, 1)), 1'b0);
                chk("rst_pulse", ev(0, 1, 0, 0, 1, 3'b000, 4'b0000));
            end
        end else if (acc) begin
            step(1'($urandom_range(0, 1)), 1'b0);
            chk("check", ev(0, 1, 0, 0, 0, 3'b000, 4'b0000));
            if (!halted) err_m = 1;
            else begin
                step(1'($urandom_range(0, 1)), 1'b0);
                chk("send_cmd", ev(0, 1, 0, 0, 0, 3'b100, 4'b0000));
                step(1'($urandom_range(0, 1)), 1'b0);
                chk("send_addr", ev(0, 1, 0, 0, 0, 3'b010, 4'b0000));
                if (wr) begin
                    step(1'($urandom_range(0, 1)), 1'b0);
                    chk("send_data", ev(0, 1, 0, 0, 0, 3'b001, 4'b0000));
                end
                repeat (no_ack ? TO : ackw) begin
                    step(1'b0, 1'b0);
                    chk("wait_ack", ev(0, 1, 0, 0, 0, 3'b000, 4'b0000));
                end
                if (no_ack) err_m = 1;
                else begin
                    step(1'b1, 1'b0);
                    chk("ack", ev(0, 1, 0, 0, 0, 3'b000, {3'b000, rd}));
                    rv = rd;
                end
            end
        end
        step(1'($urandom_range(0, 1)), 1'b1);
        chk("done", ev(0, 1, 1, rv, 0, 3'b000, 4'b0000));
        step(1'b0, 1'b0);
        chk("idle", ev(1, 0, 0, 0, 0, 3'b000, 4'b0000));
    endtask

    // port enables must never overlap
    always @(negedge clk) begin
        if (mon_en && rst) begin
            n_assert++;
            assert ($onehot0({send_cmd, send_addr, send_data})) else begin
                n_fail++;
                $error("FAIL send_onehot observed=%b expected=onehot0", {send_cmd, send_addr, send_data});
            end
        end
    end

    initial begin
        instr_valid = 0;
        core_ack = 0;
        core_halted = 0;
        debug_opcode = 0;
        rst = 1;
        #2 rst = 0;
        chk("reset", ev(1, 0, 0, 0, 0, 3'b000, 4'b0000));
        repeat (2) @(negedge clk);
        chk("reset_held", ev(1, 0, 0, 0, 0, 3'b000, 4'b0000));
        rst = 1;
        mon_en = 1;
        run_cmd(4'd1, 0, 0, 0, 0);
        run_cmd(4'd2, 0, 0, 0, 0);
        run_cmd(4'd1, 1, 0, 1, 0);
        run_cmd(4'd3, 1, 0, 0, 0);
        run_cmd(4'd6, 1, 3, 0, 0);
        run_cmd(4'd5, 1, 1, 2, 0);
        run_cmd(4'd4, 0, 0, 0, 0);
        run_cmd(4'd9, 1, 0, 0, 0);
        run_cmd(4'd0, 1, 0, 0, 0);
        run_cmd(4'd7, 1, 0, 1, 0);
        run_cmd(4'd2, 0, 0, 0, 0);
        run_cmd(4'd3, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++)
            run_cmd(4'($urandom), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 4), $urandom_range(0, 2), 0);
`ifdef DEBUG_TIMEOUT_EN
        run_cmd(4'd7, 1, 0, 0, 1);
        run_cmd(4'd0, 1, 0, 0, 0);
`endif
        run_cmd(4'd1, 0, 0, 0, 0);
        core_halted = 1;
        word(4'd4, 0, 0, 4'b1000);
        err_m = 0;
        word(4'($urandom), 0, 1, 4'b0100);
        step(0, 0);
        chk("mid_check", ev(0, 1, 0, 0, 0, 3'b000, 4'b0000));
        step(0, 0);
        chk("mid_send_cmd", ev(0, 1, 0, 0, 0, 3'b100, 4'b0000));
        step(0, 0);
        chk("mid_send_addr", ev(0, 1, 0, 0, 0, 3'b010, 4'b0000));
        step(0, 0);
        chk("mid_wait", ev(0, 1, 0, 0, 0, 3'b000, 4'b0000));
        @(posedge clk);
        #2 rst = 0;
        halt_m = 0;
        err_m = 0;
        chk("async_reset", ev(1, 0, 0, 0, 0, 3'b000, 4'b0000));
        @(negedge clk);
        rst = 1;
        core_ack = 1;
        repeat (3) begin
            step(1, 0);
            chk("post_reset_no_done", ev(1, 0, 0, 0, 0, 3'b000, 4'b0000));
        end
        run_cmd(4'd6, 1, 2, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/debug_controller.md
Name: debug_controller

Overview:
- Control FSM for the debugger datapath (command, address-argument and data-argument registers, result register, shared tristate debugger_port).
- Accepts debug instruction words from the host over a valid/ready handshake and sequences the register load enables.
- Drives the one-hot tristate send enables onto debugger_port, waits for the core's acknowledge, and captures read results.
- Owns the sticky core halt request and a timed core reset pulse.

Parameters:
- OPC_W, 4: opcode width; the opcode is debug_instruction[OPC_W-1:0].
- RESET_CYCLES, 4: length of the core_reset_request pulse, in clocks (≥1).
- TIMEOUT_CYCLES, 255: maximum clocks spent in WAIT_ACK (used only with DEBUG_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr_valid  in  1  host presents a word on debug_instruction.
- instr_ready  out  1  controller accepts a word this cycle.
- debug_opcode  in  OPC_W  low bits of debug_instruction (valid with instr_valid).
- core_ack  in  1  core has consumed the command / driven the result onto the port.
- core_halted  in  1  core status: stopped.
- core_reset_request  out  1  core reset request.
- core_halt_request  out  1  sticky core halt request.
- load_debug_command / load_debug_command_address_argument / load_debug_command_data_argument  out  1 each  register load enables.
- send_debug_command / send_debug_command_address_argument / send_debug_command_data_argument  out  1 each  tristate enables.
- load_debug_result  out  1  result register load enable.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a command completes.
- result_valid  out  1  one-cycle pulse; the result register holds new read data.
- error  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0 except instr_ready=1. Counters cleared. Reset mid-command aborts the command with no done pulse.
- Opcodes:
  - 0 NOP, 1 HALT, 2 RESUME, 3 RESET.
  - 4 RD_REG (addr), 5 WR_REG (addr, data), 6 RD_MEM (addr), 7 WR_MEM (addr, data).
  - 8..15 illegal.
- Handshake: a word transfers when instr_valid && instr_ready. instr_ready=1 only in IDLE, GET_ADDR and GET_DATA. Each load_* is asserted combinationally in its transfer cycle only.
- IDLE:
  - On transfer: load_debug_command=1, and error clears in the same cycle.
  - NOP → DONE. HALT → core_halt_request<=1, DONE. RESUME → core_halt_request<=0, DONE. RESET → RST_PULSE.
  - Opcodes 4..7 → GET_ADDR. Illegal → error<=1, DONE.
- GET_ADDR: on transfer, load_debug_command_address_argument=1. Go to GET_DATA for writes, CHECK for reads.
- GET_DATA: on transfer, load_debug_command_data_argument=1, then CHECK.
- CHECK (1 cycle): if core_halted=0 → error<=1, DONE (nothing is driven on the port). Otherwise → SEND_CMD.
- Send sequence:
  - SEND_CMD (1 cycle) → SEND_ADDR (1 cycle) → SEND_DATA (1 cycle, writes only) → WAIT_ACK.
  - Each send_* is registered and high for exactly its state's cycle.
  - At most one send_* is high in any cycle. No send_* is high in WAIT_ACK.
- WAIT_ACK: on core_ack=1:
  - Reads assert load_debug_result=1 combinationally that cycle, then DONE with result_valid=1.
  - Writes go to DONE.
  - core_ack outside WAIT_ACK is ignored.
- RST_PULSE:
  - core_reset_request=1 for exactly RESET_CYCLES clocks, counted by a down-counter; then DONE.
  - core_halt_request is unchanged.
- DONE (1 cycle): done=1, result_valid as above, → IDLE. No word is accepted in DONE.
- Back-to-back: the earliest next command acceptance is the cycle after DONE.
- Latency: RD_REG from the address transfer to done is 1 (CHECK) + 2 (send) + N (ack wait, ≥1) + 1 (DONE) clocks. Writes add 1 clock for SEND_DATA.

Optional Feature:
- Macro DEBUG_TIMEOUT_EN.
- Defined: an 8..16-bit counter, cleared on entry to WAIT_ACK, increments each WAIT_ACK cycle. If it reaches TIMEOUT_CYCLES without core_ack: error<=1, no result load, → DONE with done=1 and result_valid=0.
- Undefined: WAIT_ACK waits indefinitely; no counter logic is synthesised.

Test Plan:
- HALT (opc 1) then RESUME (opc 2) → core_halt_request rises the cycle after the first transfer and falls the cycle after the second; done pulses once per command; busy is high 1 cycle each.
- RESET (opc 3) with RESET_CYCLES=4 → core_reset_request high exactly 4 clocks, done on the following cycle, core_halt_request unchanged.
- With core_halted=1, RD_MEM: addr word, then core_ack after 3 WAIT cycles → send_cmd and send_addr in consecutive cycles, load_debug_result coincident with core_ack, result_valid the next cycle, no send_data ever.
- With core_halted=1, WR_REG: addr then data words with instr_valid gaps of 2 cycles → instr_ready is held and each load_* pulses only on its transfer. The sends are cmd, addr, data in consecutive cycles and never overlap (check the one-hot property every cycle).
- RD_REG with core_halted=0 → error=1, no send_* asserted, done pulses. Illegal opcode 9 → error=1. The next valid command clears error on acceptance.
- With DEBUG_TIMEOUT_EN and TIMEOUT_CYCLES=8, WR_MEM with no core_ack → error after 8 WAIT cycles, done=1, result_valid=0. Asserting rst low mid-WAIT_ACK instead → all outputs reset immediately and no done pulse.
